// File: rtl/decode_stage_if.sv
// Handshake bundle around decode_stage: IFU request, EXU result, writeback retire, scoreboard view.
// master = surrounding pipeline (IFU/EXU/WB), slave = the decode stage.
interface decode_stage_if #(
    parameter int REG_ADDR_W = 4
);
    localparam int NR_REGS = 1 << REG_ADDR_W;

    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_instr;
    logic [31:0]           in_pc;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_pc;
    logic [31:0]           out_instr;
    logic [REG_ADDR_W-1:0] out_rs1;
    logic [REG_ADDR_W-1:0] out_rs2;
    logic [REG_ADDR_W-1:0] out_rd;
    logic [31:0]           out_imm;
    logic [2:0]            out_class;
    logic                  out_reg_write;
    logic                  out_illegal;
    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [NR_REGS-1:0]    sb_pending;

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready, wb_valid, wb_rd,
        input  in_ready, out_valid, out_pc, out_instr, out_rs1, out_rs2, out_rd,
               out_imm, out_class, out_reg_write, out_illegal, sb_pending
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready, wb_valid, wb_rd,
        output in_ready, out_valid, out_pc, out_instr, out_rs1, out_rs2, out_rd,
               out_imm, out_class, out_reg_write, out_illegal, sb_pending
    );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32E/RV32I decode stage with a per-register RAW/WAW scoreboard.
// Latency: one cycle, accept at edge N presents decoded fields during cycle N+1.
// Backpressure: in_ready drops on hazard, flush, reset or a held result that EXU has not taken.
module decode_stage #(
    parameter int REG_ADDR_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave bus
);
    localparam int NR_REGS = 1 << REG_ADDR_W;

    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_I   = 3'd1,
        CLS_S   = 3'd2,
        CLS_B   = 3'd3,
        CLS_U   = 3'd4,
        CLS_J   = 3'd5,
        CLS_ILL = 3'd7
    } cls_e;

    typedef struct packed {
        logic [31:0]           pc;
        logic [31:0]           instr;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [31:0]           imm;
        cls_e                  cls;
        logic                  reg_write;
    } dec_t;

    logic [31:0]        instr;
    logic [6:0]         opcode;
    logic [2:0]         func3;
    cls_e               raw_cls;
    logic               raw_rs1;
    logic               raw_rs2;
    logic               raw_rd;
    logic               bad_reg;
    logic               uses_rs1;
    logic               uses_rs2;
    dec_t               dec;
    dec_t               held;
    logic               held_vld;
    logic [NR_REGS-1:0] sb;
    logic [NR_REGS-1:0] sb_next;
    logic               hazard;
    logic               rdy;
    logic               accept;

    assign instr  = bus.in_instr;
    assign opcode = instr[6:0];
    assign func3  = instr[14:12];

    always_comb begin
        raw_cls = CLS_ILL;
        case (opcode)
            7'b0110011:                                     raw_cls = CLS_R;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: raw_cls = CLS_I;
            7'b0100011:                                     raw_cls = CLS_S;
            7'b1100011:                                     raw_cls = CLS_B;
            7'b0110111, 7'b0010111:                         raw_cls = CLS_U;
            7'b1101111:                                     raw_cls = CLS_J;
            default:                                        raw_cls = CLS_ILL;
        endcase
    end

    assign raw_rs1 = raw_cls inside {CLS_R, CLS_I, CLS_S, CLS_B};
    assign raw_rs2 = raw_cls inside {CLS_R, CLS_S, CLS_B};
    assign raw_rd  = raw_cls inside {CLS_R, CLS_I, CLS_U, CLS_J};

    // RV32E has only x0..x15, so a used field reaching x16..x31 cannot be executed.
    assign bad_reg = (REG_ADDR_W == 4) &&
                     ((raw_rs1 && instr[19]) || (raw_rs2 && instr[24]) || (raw_rd && instr[11]));

    assign uses_rs1 = raw_rs1 && !bad_reg;
    assign uses_rs2 = raw_rs2 && !bad_reg;

    always_comb begin
        dec       = '0;
        dec.pc    = bus.in_pc;
        dec.instr = instr;
        dec.rs1   = instr[15 +: REG_ADDR_W];
        dec.rs2   = instr[20 +: REG_ADDR_W];
        dec.rd    = instr[7 +: REG_ADDR_W];
        dec.cls   = bad_reg ? CLS_ILL : raw_cls;
        case (dec.cls)
            CLS_I: begin
                if (opcode == 7'b0010011 && (func3 == 3'b001 || func3 == 3'b101))
                    dec.imm = {27'b0, instr[24:20]};
                else
                    dec.imm = {{20{instr[31]}}, instr[31:20]};
                dec.reg_write = !(opcode == 7'b1110011 && func3 == 3'b000);
            end
            CLS_S: dec.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            CLS_B: dec.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            CLS_U: begin
                dec.imm       = {instr[31:12], 12'b0};
                dec.reg_write = 1'b1;
            end
            CLS_J: begin
                dec.imm       = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                dec.reg_write = 1'b1;
            end
            CLS_R:   dec.reg_write = 1'b1;
            default: dec.reg_write = 1'b0;
        endcase
    end

    // No writeback bypass: a retire this cycle only unblocks issue next cycle.
    assign hazard = (uses_rs1 && sb[dec.rs1]) ||
                    (uses_rs2 && sb[dec.rs2]) ||
                    (dec.reg_write && dec.rd != '0 && sb[dec.rd]);

    assign rdy    = !rst && !bus.flush && !hazard && (!held_vld || bus.out_ready);
    assign accept = bus.in_valid && rdy;

    always_comb begin
        sb_next = sb;
        if (bus.wb_valid)
            sb_next[bus.wb_rd] = 1'b0;
        if (bus.flush && held_vld && held.reg_write)
            sb_next[held.rd] = 1'b0;
        if (accept && dec.reg_write)
            sb_next[dec.rd] = 1'b1;
        sb_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held     <= '0;
            held_vld <= 1'b0;
            sb       <= '0;
        end else begin
            sb <= sb_next;
            if (bus.flush) begin
                held_vld <= 1'b0;
            end else if (accept) begin
                held     <= dec;
                held_vld <= 1'b1;
            end else if (bus.out_ready) begin
                held_vld <= 1'b0;
            end
        end
    end

    assign bus.in_ready      = rdy;
    assign bus.out_valid     = held_vld;
    assign bus.out_pc        = held.pc;
    assign bus.out_instr     = held.instr;
    assign bus.out_rs1       = held.rs1;
    assign bus.out_rs2       = held.rs2;
    assign bus.out_rd        = held.rd;
    assign bus.out_imm       = held.imm;
    assign bus.out_class     = held.cls;
    assign bus.out_reg_write = held.reg_write;
    assign bus.out_illegal   = (held.cls == CLS_ILL);
    assign bus.sb_pending    = sb;
endmodule
